// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a tune held in a small RAM by driving the tone
// generator's key-code input with per-note durations and optional gaps.
// Entry format: [7]=rest, [6:4]=note index, [3:0]=duration in ticks
// (duration 0 marks the end of the melody).
module melody_sequencer #(
  parameter int TICK_DIV   = 5000000,
  parameter int MELODY_LEN = 16,
  parameter int GAP_TICKS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(MELODY_LEN)-1:0] wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop,
  output logic [7:0]                    note_code,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MELODY_LEN)-1:0] step
);

  localparam int AW = $clog2(MELODY_LEN);
  localparam int CW = $clog2(TICK_DIV);
  // Tick counter must hold both a 4-bit duration and the gap length.
  localparam int TW = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : 4;

  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [AW-1:0] STEP_LAST = AW'(MELODY_LEN - 1);
  localparam logic [AW-1:0] STEP_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Key code expected by the tone generator for each note index.
  function automatic logic [7:0] note_to_code(input logic [2:0] idx);
    logic [7:0] code;
    case (idx)
      3'd0:    code = 8'h11;
      3'd1:    code = 8'h12;
      3'd2:    code = 8'h14;
      3'd3:    code = 8'h18;
      3'd4:    code = 8'h21;
      3'd5:    code = 8'h22;
      3'd6:    code = 8'h24;
      3'd7:    code = 8'h28;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // A rest entry plays silence for its duration.
  function automatic logic [7:0] entry_code(input logic rest, input logic [2:0] idx);
    return rest ? 8'h00 : note_to_code(idx);
  endfunction

  // Zero duration is the end-of-melody marker.
  function automatic logic entry_is_end(input logic [3:0] dur);
    return (dur == 4'd0);
  endfunction

  logic [7:0]    ram_q [MELODY_LEN];
  logic          ram_we_s;

  state_e        state_q, state_d;
  logic [AW-1:0] step_q, step_d;
  logic [7:0]    note_code_q, note_code_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [TW-1:0] tick_q, tick_d;

  logic [7:0]    first_entry_s;
  logic [7:0]    cur_entry_s;
  logic [7:0]    next_entry_s;
  logic [AW-1:0] next_addr_s;
  logic          cyc_wrap_s;
  logic          note_last_s;
  logic          gap_last_s;

  state_e        adv_state_s;
  logic [AW-1:0] adv_step_s;
  logic [7:0]    adv_code_s;
  logic          adv_busy_s;
  logic          adv_done_s;

  // Melody RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  assign next_addr_s   = step_q + STEP_ONE;
  assign first_entry_s = ram_q[0];
  assign cur_entry_s   = ram_q[step_q];
  assign next_entry_s  = ram_q[next_addr_s];

  // Decode the final cycle of the current note and of the current gap.
  always_comb begin
    cyc_wrap_s  = (cyc_q == CYC_LAST);
    note_last_s = cyc_wrap_s && (tick_q == (TW'(cur_entry_s[3:0]) - TICK_ONE));
    gap_last_s  = cyc_wrap_s && (tick_q == GAP_LAST);
  end

  // Choose the follow-on entry once a note (and its gap) has finished.
  always_comb begin
    adv_state_s = S_NOTE;
    adv_step_s  = '0;
    adv_code_s  = 8'h00;
    adv_busy_s  = 1'b1;
    adv_done_s  = 1'b0;
    if ((step_q != STEP_LAST) && !entry_is_end(next_entry_s[3:0])) begin
      adv_step_s = next_addr_s;
      adv_code_s = entry_code(next_entry_s[7], next_entry_s[6:4]);
    end else if (loop && !entry_is_end(first_entry_s[3:0])) begin
      adv_code_s = entry_code(first_entry_s[7], first_entry_s[6:4]);
    end else begin
      adv_state_s = S_IDLE;
      adv_busy_s  = 1'b0;
      adv_done_s  = 1'b1;
    end
  end

  // Next-state and registered-output logic of the playback FSM.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    note_code_d = note_code_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cyc_d       = cyc_q;
    tick_d      = tick_q;
    ram_we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        note_code_d = 8'h00;
        busy_d      = 1'b0;
        step_d      = '0;
        cyc_d       = '0;
        tick_d      = '0;
        ram_we_s    = wr_en;
        if (start && !stop) begin
          if (entry_is_end(first_entry_s[3:0])) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_NOTE;
            note_code_d = entry_code(first_entry_s[7], first_entry_s[6:4]);
            busy_d      = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NOTE, S_GAP: begin
        if (stop) begin
          state_d     = S_IDLE;
          note_code_d = 8'h00;
          busy_d      = 1'b0;
          step_d      = '0;
          cyc_d       = '0;
          tick_d      = '0;
        end else if ((state_q == S_NOTE) && note_last_s && (GAP_TICKS > 0)) begin
          state_d     = S_GAP;
          note_code_d = 8'h00;
          cyc_d       = '0;
          tick_d      = '0;
        end else if (((state_q == S_NOTE) && note_last_s) ||
                     ((state_q == S_GAP) && gap_last_s)) begin
          state_d     = adv_state_s;
          step_d      = adv_step_s;
          note_code_d = adv_code_s;
          busy_d      = adv_busy_s;
          done_d      = adv_done_s;
          cyc_d       = '0;
          tick_d      = '0;
        end else if (cyc_wrap_s) begin
          cyc_d  = '0;
          tick_d = tick_q + TICK_ONE;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        note_code_d = 8'h00;
        busy_d      = 1'b0;
        step_d      = '0;
        cyc_d       = '0;
        tick_d      = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      note_code_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_q       <= '0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      note_code_q <= note_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cyc_q       <= cyc_d;
      tick_q      <= tick_d;
    end
  end

  assign note_code = note_code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step      = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (gap of one tick / no gap)
// share stimulus; a timeline model expands the melody into per-cycle
// expected outputs.
module tb_melody_sequencer;

  localparam int TD  = 4;
  localparam int LEN = 4;
  localparam int MAXT = 128;

  typedef struct packed {
    logic [7:0] code;
    logic       busy;
    logic       done;
    logic [1:0] step;
  } obs_t;

  typedef struct {
    logic [7:0] entry;
    logic [7:0] exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] code_g0, code_g1;
  logic       busy_g0, busy_g1, done_g0, done_g1;
  logic [1:0] step_g0, step_g1;

  int   total = 0;
  int   bad   = 0;
  obs_t tr [2][MAXT];
  int   tlen [2];
  int   bcount [2];
  logic [7:0] mdl_mem [LEN];
  vec_t vecs [9];

  melody_sequencer #(.TICK_DIV(TD), .MELODY_LEN(LEN), .GAP_TICKS(0)) dut_g0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .note_code(code_g0), .busy(busy_g0), .done(done_g0), .step(step_g0)
  );

  melody_sequencer #(.TICK_DIV(TD), .MELODY_LEN(LEN), .GAP_TICKS(1)) dut_g1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .note_code(code_g1), .busy(busy_g1), .done(done_g1), .step(step_g1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t act_obs(input int g);
    obs_t o;
    if (g == 0) o = {code_g0, busy_g0, done_g0, step_g0};
    else        o = {code_g1, busy_g1, done_g1, step_g1};
    return o;
  endfunction

  // Key code from note index: low octave 0x1_, high 0x2_, one-hot low nibble.
  function automatic logic [7:0] model_code(input logic [7:0] e);
    logic [7:0] base;
    logic [7:0] one;
    if (e[7]) return 8'h00;
    one  = 8'h01;
    base = (e[6:4] < 3'd4) ? 8'h10 : 8'h20;
    return base | (one << e[5:4]);
  endfunction

  // Expand the model RAM into a per-cycle timeline for each gap setting.
  task automatic build_traces();
    for (int g = 0; g < 2; g++) begin
      int   n;
      logic ended;
      obs_t o;
      n = 0;
      ended = 1'b0;
      for (int i = 0; i < LEN; i++) begin
        if (!ended && mdl_mem[i][3:0] == 4'd0) ended = 1'b1;
        if (!ended) begin
          o.code = model_code(mdl_mem[i]);
          o.busy = 1'b1;
          o.done = 1'b0;
          o.step = i[1:0];
          for (int k = 0; k < int'(mdl_mem[i][3:0]) * TD; k++) begin
            tr[g][n] = o;
            n++;
          end
          o.code = 8'h00;
          for (int k = 0; k < g * TD; k++) begin
            tr[g][n] = o;
            n++;
          end
        end
      end
      tlen[g] = n;
    end
  endtask

  function automatic obs_t exp_obs(input int g, input int c, input logic lp, input int stop_idx);
    obs_t idle_o;
    obs_t done_o;
    int   l;
    l = tlen[g];
    idle_o = '0;
    done_o = '0;
    done_o.done = 1'b1;
    if (l == 0) return (c == 0) ? done_o : idle_o;
    if (stop_idx >= 0 && (lp || stop_idx < l) && c > stop_idx) return idle_o;
    if (lp || c < l) return tr[g][c % l];
    if (c == l) return done_o;
    return idle_o;
  endfunction

  task automatic check(input string name, input int g, input obs_t exp);
    obs_t act;
    act = act_obs(g);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s gap%0d: got code=%h busy=%b done=%b step=%0d, want code=%h busy=%b done=%b step=%0d",
               name, g, act.code, act.busy, act.done, act.step, exp.code, exp.busy, exp.done, exp.step);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic write_ram(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    mdl_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load4(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    write_ram(2'd0, e0);
    write_ram(2'd1, e1);
    write_ram(2'd2, e2);
    write_ram(2'd3, e3);
  endtask

  task automatic check_idle(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(name, 0, obs_t'(12'h000));
      check(name, 1, obs_t'(12'h000));
    end
  endtask

  // Start playback and compare every cycle; optional stop and an ignored start+write.
  task automatic run_play(input string name, input logic lp, input int stop_idx, input int junk_idx);
    int ncyc;
    int maxl;
    build_traces();
    bcount[0] = 0;
    bcount[1] = 0;
    maxl = (tlen[0] > tlen[1]) ? tlen[0] : tlen[1];
    ncyc = (lp && maxl > 0) ? stop_idx + 3 : maxl + 2;
    @(negedge clk);
    start = 1'b1;
    loop = lp;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      wr_en = 1'b0;
      for (int g = 0; g < 2; g++) begin
        obs_t a;
        check(name, g, exp_obs(g, c, lp, stop_idx));
        a = act_obs(g);
        if (a.busy) bcount[g]++;
      end
      if (c == stop_idx) stop = 1'b1;
      if (c == junk_idx && c < tlen[0] && c < tlen[1] && (stop_idx < 0 || c <= stop_idx)) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_data = 8'h5F;
      end
    end
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    wr_en = 1'b0;
    loop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h11};
    vecs[1] = '{8'h11, 8'h12};
    vecs[2] = '{8'h21, 8'h14};
    vecs[3] = '{8'h31, 8'h18};
    vecs[4] = '{8'h41, 8'h21};
    vecs[5] = '{8'h51, 8'h22};
    vecs[6] = '{8'h61, 8'h24};
    vecs[7] = '{8'h71, 8'h28};
    vecs[8] = '{8'hF1, 8'h00};

    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h00;
    start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    #12;
    check("reset", 0, obs_t'(12'h000));
    check("reset", 1, obs_t'(12'h000));
    @(negedge clk);
    rst = 1'b1;

    // Note-index decode table: first cycle of playback shows the key code.
    for (int v = 0; v < 9; v++) begin
      write_ram(2'd0, vecs[v].entry);
      write_ram(2'd1, 8'h00);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("decode", 0, {vecs[v].exp_code, 1'b1, 1'b0, 2'd0});
      check("decode", 1, {vecs[v].exp_code, 1'b1, 1'b0, 2'd0});
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("decode_stop", 0, obs_t'(12'h000));
      check("decode_stop", 1, obs_t'(12'h000));
    end

    // Basic melody, no loop: busy for 20 cycles with gaps, 12 without.
    load4(8'h02, 8'h51, 8'h00, 8'h00);
    run_play("basic", 1'b0, -1, -1);
    check_int("busy_cycles_gap1", bcount[1], 20);
    check_int("busy_cycles_gap0", bcount[0], 12);

    // Loop back to entry 0 without a done pulse, then stop.
    run_play("loop", 1'b1, 30, -1);

    // Full RAM, no end marker.
    load4(8'h71, 8'h61, 8'h91, 8'h01);
    run_play("full_ram", 1'b0, -1, -1);

    // Stop 6 cycles into the first note, then replay from entry 0.
    load4(8'h02, 8'h51, 8'h00, 8'h00);
    run_play("stop_mid", 1'b0, 5, -1);
    run_play("replay", 1'b0, -1, -1);

    // Write and start while busy are ignored; later playback proves RAM intact.
    run_play("busy_write", 1'b0, -1, 3);
    run_play("after_busy_write", 1'b0, -1, -1);

    // start and stop together in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_idle", 0, obs_t'(12'h000));
    check("start_stop_idle", 1, obs_t'(12'h000));
    check_idle("start_stop_idle", 2);

    // End marker at entry 0: immediate done, busy never set.
    write_ram(2'd0, 8'h30);
    run_play("empty", 1'b0, -1, -1);

    // Asynchronous reset mid-note.
    load4(8'h13, 8'h22, 8'h00, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 0, obs_t'(12'h000));
    check("async_reset", 1, obs_t'(12'h000));
    @(negedge clk);
    rst = 1'b1;
    check_idle("after_reset", 3);
    load4(8'h13, 8'h22, 8'h00, 8'h00);
    run_play("after_reset_play", 1'b0, -1, -1);

    // Randomized melodies, loop, stop and ignored busy accesses.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] e;
      logic       lp;
      int         sidx;
      int         jidx;
      for (int i = 0; i < LEN; i++) begin
        e = 8'($urandom);
        e[3:0] = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        write_ram(2'(i), e);
      end
      lp = ($urandom_range(0, 3) == 0);
      if (lp) sidx = $urandom_range(0, 60);
      else if ($urandom_range(0, 1) == 1) sidx = $urandom_range(0, 70);
      else sidx = -1;
      jidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1;
      run_play("random", lp, sidx, jidx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a stored tune by driving the 8-bit note-select input of the tone generator (`diods`) with per-note durations and inter-note gaps.
- Sits between the host/keypad logic and the tone generator.
- Holds a small melody RAM that the host loads while the sequencer is idle. Playback is then started and stopped with single-cycle pulses.
- Output encoding matches the tone generator's key-code decode exactly.

Parameters:
- TICK_DIV, 5000000, clock cycles per duration tick (100 ms at 50 MHz); minimum 2
- MELODY_LEN, 16, melody RAM depth in entries (power of 2, max 256)
- GAP_TICKS, 1, silent ticks inserted after every entry; 0 disables the gap

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  melody RAM write strobe; honoured only in IDLE
- wr_addr  in  $clog2(MELODY_LEN)  RAM write address
- wr_data  in  8  entry: [7]=rest, [6:4]=note index, [3:0]=duration in ticks
- start  in  1  single-cycle pulse; begins playback from entry 0
- stop  in  1  single-cycle pulse; aborts playback
- loop  in  1  sampled at end of melody; 1 = restart at entry 0
- note_code  out  8  to tone generator `diods`; registered
- busy  out  1  high in NOTE or GAP
- done  out  1  one-cycle pulse on natural melody completion
- step  out  $clog2(MELODY_LEN)  index of the entry currently playing

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - Values after reset: note_code=8'h00, busy=0, done=0, step=0, state=IDLE, tick counters=0.
  - RAM contents are undefined after reset.
- Note index to note_code mapping:
  - 0 → 8'h11 (c), 1 → 8'h12 (d), 2 → 8'h14 (e), 3 → 8'h18 (f)
  - 4 → 8'h21 (g), 5 → 8'h22 (a), 6 → 8'h24 (h), 7 → 8'h28 (high C)
  - Silence → 8'h00.
- Entry semantics:
  - rest=1 with duration≠0: silence for duration ticks.
  - duration=0, any rest value: end-of-melody marker. It consumes no time and no gap.
- State IDLE:
  - note_code=0, busy=0.
  - wr_en writes the RAM.
  - start (with stop low) goes to NOTE on the next edge. At that edge: step=0, note_code is loaded from entry 0, and the cycle counter is cleared.
- State NOTE:
  - note_code is held for duration×TICK_DIV clk cycles, counted from the first cycle it is valid.
  - If GAP_TICKS>0, go to GAP; otherwise advance directly.
- State GAP:
  - note_code=0 for GAP_TICKS×TICK_DIV cycles, then advance.
- Advance:
  - If step=MELODY_LEN-1, or the next entry is an end marker, the melody ends. Otherwise step++, load the next entry, and return to NOTE.
  - The next entry's note_code is valid on the cycle immediately after the last gap/note cycle, so there are no dead cycles.
- End of melody:
  - loop=1: step=0, load entry 0, go to NOTE. done is not pulsed.
  - loop=0: go to IDLE with note_code=0. done=1 for exactly one cycle, coincident with busy falling.
- End marker at entry 0:
  - start goes straight to IDLE next cycle with done pulsed.
  - busy is never asserted.
- stop:
  - In NOTE or GAP: IDLE on the next edge, note_code=0, step=0, no done pulse.
  - In IDLE: ignored.
- Simultaneous events:
  - start and stop together: stop wins.
  - start while busy: ignored.
  - wr_en while busy: ignored, RAM unchanged.
- Reset mid-playback: outputs go to reset values immediately (asynchronous).
- Counters:
  - The cycle counter wraps at TICK_DIV-1 and increments the tick counter.
  - Both counters clear on every state entry.

Test Plan:
- TICK_DIV=4, GAP_TICKS=1, loop=0. Write entries {0x02, 0x51, 0x00} and pulse start → expected sequence:
  - note_code=8'h11 for 8 cycles, then 0 for 4 cycles
  - 8'h22 for 4 cycles, then 0 for 4 cycles
  - IDLE, with done high for 1 cycle; busy high for 20 cycles total.
- Same melody with loop=1 → after the second gap, note_code=8'h11 again on the very next cycle, step=0, and done never pulses.
- Full RAM with MELODY_LEN=4, entries {0x71, 0x61, 0x91, 0x01}, GAP_TICKS=0 → expected outputs:
  - note_code sequence 8'h28 / 8'h24 / 8'h00 (rest) / 8'h11, 4 cycles each
  - step sequence 0→3, then done.
- Assert stop 6 cycles into a note → note_code=0 and busy=0 on the next cycle, no done pulse. A following start replays from entry 0.
- Issue wr_en to address 0 while busy, and start+stop in the same IDLE cycle → RAM entry 0 is unchanged (verified by a later playback) and the sequencer stays in IDLE.
- Drive rst low mid-note → note_code=0, busy=0, step=0 without a clock edge. After release the sequencer stays in IDLE until start.
